// File: rtl/trng_sched.sv
// trng_sched: discards TRNG warm-up bits, packs words and hands them out round-robin.
// Optional repetition-count health test is compiled in with TRNG_SCHED_HEALTH_EN.
module trng_sched #(
    parameter int NREQ        = 4,
    parameter int WORD_W      = 16,
    parameter int WARMUP_BITS = 64,
    parameter int RCT_LIMIT   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   ack,
    input  logic              clear_fail,
    output logic [NREQ-1:0]   gnt,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              fail
);
    localparam int CNT_MAX = (WARMUP_BITS > WORD_W) ? WARMUP_BITS : WORD_W;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP_BITS - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WORD_W - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    typedef enum logic [2:0] {WARMUP, COLLECT, ARB, DELIVER, FAIL} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] shreg;
    logic [IW-1:0]     last;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     scan_idx;
    logic              found;
    logic              trip;

    // First requester at or after last+1, wrapping.
    always_comb begin
        pick     = last;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = IW'((int'(last) + i) % NREQ);
            if (!found && req[scan_idx]) begin
                pick  = scan_idx;
                found = 1'b1;
            end
        end
    end

`ifdef TRNG_SCHED_HEALTH_EN
    localparam int RW = $clog2(RCT_LIMIT + 1);
    localparam logic [RW-1:0] RUN_LIMIT = RW'(RCT_LIMIT);

    logic [RW-1:0] run;
    logic [RW-1:0] run_nxt;
    logic          prev;

    always_comb begin
        run_nxt = run;
        if (run == '0 || bit_in != prev)
            run_nxt = RW'(1);
        else if (run != '1)
            run_nxt = run + 1'b1;
    end

    assign trip = bit_valid && (state != FAIL) && (run_nxt >= RUN_LIMIT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            run  <= '0;
            prev <= 1'b0;
        end else if (state == FAIL) begin
            if (clear_fail)
                run <= '0;
        end else if (bit_valid) begin
            run  <= run_nxt;
            prev <= bit_in;
        end
    end
`else
    logic unused_health;
    assign unused_health = clear_fail | (RCT_LIMIT < 2);
    assign trip = 1'b0;
    assign fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= WARMUP;
            cnt        <= '0;
            shreg      <= '0;
            last       <= LAST_INIT;
            gnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
`ifdef TRNG_SCHED_HEALTH_EN
            fail       <= 1'b0;
`endif
        end else if (trip) begin
            // A trip overrides whatever the current state would do, including an ack.
            state      <= FAIL;
            cnt        <= '0;
            gnt        <= '0;
            word_valid <= 1'b0;
`ifdef TRNG_SCHED_HEALTH_EN
            fail       <= 1'b1;
`endif
        end else begin
            case (state)
                WARMUP: if (bit_valid) begin
                    if (cnt == WARM_LAST) begin
                        cnt   <= '0;
                        state <= COLLECT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COLLECT: if (bit_valid) begin
                    shreg <= {shreg[WORD_W-2:0], bit_in};
                    if (cnt == WORD_LAST) begin
                        cnt   <= '0;
                        state <= ARB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB: if (|req) begin
                    gnt        <= NREQ'(1) << pick;
                    word_out   <= shreg;
                    word_valid <= 1'b1;
                    last       <= pick;
                    state      <= DELIVER;
                end
                DELIVER: begin
                    if (ack[last]) begin
                        gnt        <= '0;
                        word_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= COLLECT;
                    end else if (!req[last]) begin
                        gnt        <= '0;
                        word_valid <= 1'b0;
                        state      <= ARB;
                    end
                end
                FAIL: begin
`ifdef TRNG_SCHED_HEALTH_EN
                    if (clear_fail) begin
                        fail  <= 1'b0;
                        cnt   <= '0;
                        state <= WARMUP;
                    end
`else
                    state <= WARMUP;
`endif
                end
                default: state <= WARMUP;
            endcase
        end
    end
endmodule

// File: tb/tb_trng_sched.sv
// Bench for trng_sched: random bit streams checked against a word/grant model
// built from the discard, packing and round-robin rules.
module tb_trng_sched;
    localparam int NREQ        = 4;
    localparam int WORD_W      = 16;
    localparam int WARMUP_BITS = 64;
    localparam int RCT_LIMIT   = 32;
    localparam int PERIOD      = WORD_W + 2;
    localparam int B2B_N       = 3 * PERIOD;

    logic              clk = 1'b0;
    logic              reset;
    logic              bit_in;
    logic              bit_valid;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   ack;
    logic              clear_fail;
    logic [NREQ-1:0]   gnt;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              fail;

    int total = 0;
    int bad   = 0;
    int m_last;

    trng_sched #(
        .NREQ(NREQ), .WORD_W(WORD_W), .WARMUP_BITS(WARMUP_BITS), .RCT_LIMIT(RCT_LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .req(req), .ack(ack), .clear_fail(clear_fail),
        .gnt(gnt), .word_out(word_out), .word_valid(word_valid), .fail(fail)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int rr_pick(input int lst, input logic [NREQ-1:0] r);
        for (int i = 1; i <= NREQ; i++)
            if (r[(lst + i) % NREQ]) return (lst + i) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int idx);
        return NREQ'(1) << idx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_warmup();
        for (int i = 0; i < WARMUP_BITS; i++) send_bit(i % 2 == 0);
    endtask

    task automatic send_word(output logic [WORD_W-1:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < WORD_W; i++) begin
            b = 1'($urandom_range(1, 0));
            w = {w[WORD_W-2:0], b};
            send_bit(b);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_reset();
        reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
        req = '0; ack = '0; clear_fail = 1'b0;
        tick(); tick();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b want=0000", gnt); end
        total++; if (word_out !== 16'h0000) begin bad++; $display("FAIL rst_word got=%h want=0000", word_out); end
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", word_valid); end
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL rst_fail got=%b want=0", fail); end
        reset  = 1'b1;
        m_last = NREQ - 1;
    endtask

    task automatic test_warmup();
        req = 4'b0001;
        send_warmup();
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL warm_valid_early got=%b want=0", word_valid); end
        for (int i = 0; i < WORD_W; i++) send_bit(i % 2 == 0);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL warm_gnt_latency got=%b want=0000", gnt); end
        tick();
        m_last = rr_pick(m_last, req);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL warm_gnt got=%b want=0001", gnt); end
        total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL warm_valid got=%b want=1", word_valid); end
        total++; if (word_out !== 16'hAAAA) begin bad++; $display("FAIL warm_word got=%h want=aaaa", word_out); end
        ack = 4'b0001;
        tick();
        ack = '0;
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL warm_ack_valid got=%b want=0", word_valid); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL warm_ack_gnt got=%b want=0000", gnt); end
        req = '0;
    endtask

    task automatic test_round_robin();
        logic [WORD_W-1:0] w;
        logic [NREQ-1:0]   eg;
        pulse_reset();
        send_warmup();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            send_word(w);
            tick();
            m_last = rr_pick(m_last, req);
            eg     = onehot(m_last);
            total++; if (gnt !== eg) begin bad++; $display("FAIL rr_gnt[%0d] got=%b want=%b", k, gnt, eg); end
            total++; if (!$onehot(gnt)) begin bad++; $display("FAIL rr_onehot[%0d] got=%b want=one-hot", k, gnt); end
            total++; if (word_out !== w) begin bad++; $display("FAIL rr_word[%0d] got=%h want=%h", k, word_out, w); end
            tick();
            total++; if (word_valid !== 1'b1) begin bad++; $display("FAIL rr_hold[%0d] got=%b want=1", k, word_valid); end
            ack = eg;
            tick();
            ack = '0;
            total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL rr_ack[%0d] got=%b want=0", k, word_valid); end
        end
        req = '0;
    endtask

    task automatic test_back_to_back();
        logic              b [B2B_N];
        logic [WORD_W-1:0] words [3];
        logic              ev;
        for (int k = 0; k < 3; k++) words[k] = '0;
        for (int e = 0; e < B2B_N; e++) begin
            b[e] = 1'($urandom_range(1, 0));
            if (e % PERIOD < WORD_W) words[e / PERIOD] = {words[e / PERIOD][WORD_W-2:0], b[e]};
        end
        req = 4'b0001; ack = 4'b0001; bit_valid = 1'b1;
        for (int e = 0; e < B2B_N; e++) begin
            bit_in = b[e];
            tick();
            ev = (e % PERIOD == WORD_W);
            total++; if (word_valid !== ev) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=%b", e, word_valid, ev); end
            if (ev) begin
                total++; if (word_out !== words[e / PERIOD]) begin bad++; $display("FAIL b2b_word[%0d] got=%h want=%h", e, word_out, words[e / PERIOD]); end
                total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt[%0d] got=%b want=0001", e, gnt); end
            end
        end
        bit_valid = 1'b0; ack = '0; req = '0;
        m_last = 0;
    endtask

    task automatic test_withdraw();
        logic [WORD_W-1:0] w;
        logic [NREQ-1:0]   eg;
        req = 4'b1100;
        send_word(w);
        tick();
        m_last = rr_pick(m_last, req);
        eg     = onehot(m_last);
        total++; if (gnt !== eg) begin bad++; $display("FAIL wd_gnt1 got=%b want=%b", gnt, eg); end
        ack = 4'b0001; clear_fail = 1'b1;
        tick();
        ack = '0; clear_fail = 1'b0;
        total++; if (gnt !== eg || word_valid !== 1'b1) begin bad++; $display("FAIL wd_stray_ack got=%b/%b want=%b/1", gnt, word_valid, eg); end
        req = 4'b1000;
        tick();
        total++; if (word_valid !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL wd_drop got=%b/%b want=0000/0", gnt, word_valid); end
        req = '0;
        tick(); tick();
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL wd_idle got=%b want=0", word_valid); end
        req = 4'b1000;
        tick();
        m_last = rr_pick(m_last, req);
        eg     = onehot(m_last);
        total++; if (gnt !== eg) begin bad++; $display("FAIL wd_gnt2 got=%b want=%b", gnt, eg); end
        total++; if (word_out !== w) begin bad++; $display("FAIL wd_word got=%h want=%h", word_out, w); end
        ack = eg;
        tick();
        ack = '0; req = '0;
        total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL wd_ack got=%b want=0", word_valid); end
    endtask

`ifdef TRNG_SCHED_HEALTH_EN
    task automatic test_health();
        logic [WORD_W-1:0] w;
        logic [NREQ-1:0]   eg;
        req = '0;
        send_bit(1'b0);
        for (int i = 0; i < RCT_LIMIT - 1; i++) send_bit(1'b1);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL hl_before got=%b want=0", fail); end
        send_bit(1'b1);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL hl_trip got=%b want=1", fail); end
        total++; if (gnt !== 4'b0000 || word_valid !== 1'b0) begin bad++; $display("FAIL hl_outs got=%b/%b want=0000/0", gnt, word_valid); end
        send_bit(1'b0); send_bit(1'b1);
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL hl_sticky got=%b want=1", fail); end
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL hl_clear got=%b want=0", fail); end
        req = 4'b0001;
        send_warmup();
        send_word(w);
        tick();
        m_last = rr_pick(m_last, req);
        eg     = onehot(m_last);
        total++; if (gnt !== eg) begin bad++; $display("FAIL hl_regnt got=%b want=%b", gnt, eg); end
        total++; if (word_out !== w) begin bad++; $display("FAIL hl_word got=%h want=%h", word_out, w); end
        ack = eg;
        tick();
        ack = '0;
    endtask

    task automatic test_trip_vs_ack();
        req = 4'b0001;
        send_bit(1'b0);
        for (int i = 0; i < WORD_W - 1; i++) send_bit(1'b1);
        bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        total++; if (gnt !== 4'b0001 || word_out !== 16'h7FFF) begin bad++; $display("FAIL tva_gnt got=%b/%h want=0001/7fff", gnt, word_out); end
        for (int i = 0; i < RCT_LIMIT - WORD_W - 1; i++) tick();
        total++; if (fail !== 1'b0 || word_valid !== 1'b1) begin bad++; $display("FAIL tva_pre got=%b/%b want=0/1", fail, word_valid); end
        ack = 4'b0001;
        tick();
        ack = '0; bit_valid = 1'b0;
        total++; if (fail !== 1'b1) begin bad++; $display("FAIL tva_fail got=%b want=1", fail); end
        total++; if (word_valid !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL tva_outs got=%b/%b want=0000/0", gnt, word_valid); end
        for (int i = 0; i < WORD_W + 4; i++) send_bit(1'($urandom_range(1, 0)));
        total++; if (word_valid !== 1'b0 || fail !== 1'b1) begin bad++; $display("FAIL tva_nocollect got=%b/%b want=0/1", word_valid, fail); end
        req = '0;
    endtask
`else
    task automatic test_no_health();
        req = '0;
        send_bit(1'b0);
        for (int i = 0; i < RCT_LIMIT + 8; i++) send_bit(1'b1);
        total++; if (fail !== 1'b0) begin bad++; $display("FAIL nh_fail got=%b want=0", fail); end
        req = 4'b0001;
        tick();
        m_last = rr_pick(m_last, req);
        total++; if (gnt !== onehot(m_last)) begin bad++; $display("FAIL nh_gnt got=%b want=%b", gnt, onehot(m_last)); end
        total++; if (word_out !== 16'h7FFF) begin bad++; $display("FAIL nh_word got=%h want=7fff", word_out); end
        ack = 4'b0001;
        tick();
        ack = '0; req = '0;
    endtask
`endif

    task automatic test_reset_mid_deliver();
        logic [WORD_W-1:0] w;
        pulse_reset();
        send_warmup();
        req = 4'b0010;
        send_word(w);
        tick();
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rmd_pre got=%b want=0010", gnt); end
        reset = 1'b0;
        tick();
        reset  = 1'b1;
        m_last = NREQ - 1;
        total++; if (gnt !== 4'b0000 || word_valid !== 1'b0) begin bad++; $display("FAIL rmd_outs got=%b/%b want=0000/0", gnt, word_valid); end
        total++; if (word_out !== 16'h0000 || fail !== 1'b0) begin bad++; $display("FAIL rmd_word got=%h/%b want=0000/0", word_out, fail); end
        req = 4'b1111;
        send_warmup();
        send_word(w);
        tick();
        m_last = rr_pick(m_last, req);
        total++; if (gnt !== onehot(m_last)) begin bad++; $display("FAIL rmd_gnt got=%b want=%b", gnt, onehot(m_last)); end
        total++; if (word_out !== w) begin bad++; $display("FAIL rmd_word2 got=%h want=%h", word_out, w); end
        ack = onehot(m_last);
        tick();
        ack = '0; req = '0;
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_round_robin();
        test_back_to_back();
        test_withdraw();
`ifdef TRNG_SCHED_HEALTH_EN
        test_health();
        test_trip_vs_ack();
`else
        test_no_health();
`endif
        test_reset_mid_deliver();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trng_sched.md
# trng_sched

Controller and arbiter that sits between the `trng` output bit stream and multiple consumers. It discards a warm-up run of bits, packs valid bits into words, and hands each word to one requester under round-robin arbitration with a req/ack handshake. An optional repetition-count health test halts delivery when the source sticks.

## Interface

Parameters:
- `NREQ`, 4: number of requesters (≥2).
- `WORD_W`, 16: delivered word width.
- `WARMUP_BITS`, 64: valid bits discarded after reset or fault clear (≥1).
- `RCT_LIMIT`, 32: consecutive identical bits that trip the health test (≥2).

Ports:
- `clk`, in, 1: single clock; all logic on posedge.
- `reset`, in, 1: synchronous, active-low. Logic is reset on any posedge with `reset`==0.
- `bit_in`, in, 1: TRNG output bit (`trng.out`).
- `bit_valid`, in, 1: `bit_in` qualifier (`trng.out_valid`).
- `req`, in, NREQ: per-requester word request, level.
- `ack`, in, NREQ: per-requester consume strobe.
- `clear_fail`, in, 1: leave FAIL state (pulse).
- `gnt`, out, NREQ: one-hot grant (all-zero when idle).
- `word_out`, out, WORD_W: word being offered.
- `word_valid`, out, 1: `word_out` valid to granted requester.
- `fail`, out, 1: health fault, sticky.

## Operation

States: WARMUP, COLLECT, ARB, DELIVER, FAIL. All outputs are registered.

- **WARMUP**: counts valid bits up to WARMUP_BITS and discards them. On the edge that samples the WARMUP_BITS-th bit, go to COLLECT. The bit counter is `$clog2(max(WARMUP_BITS,WORD_W)+1)` bits wide.
- **COLLECT**: on each valid bit, `shreg <= {shreg[WORD_W-2:0], bit_in}` (first bit ends up at the MSB). On the edge that samples the WORD_W-th bit, go to ARB.
- **ARB**: the word is held and further `bit_in` is not packed. If `req` is nonzero, pick the first set requester scanning from `last+1` with wrap. Register `gnt`, set `word_valid`=1, `word_out`=shreg, update `last`, go to DELIVER. With no request, stay in ARB indefinitely.
- **DELIVER**:
  - If `ack[g]`=1 for the granted index g: clear `gnt`/`word_valid` and go to COLLECT with the counter at 0.
  - Else if `req[g]`=0: clear `gnt`/`word_valid` and return to ARB with the word retained. `last` is not rolled back.
  - `ack` on non-granted indices is ignored. `ack` without `req` still counts as consumption.
- **FAIL**: `gnt`=0, `word_valid`=0, `fail`=1. The word is discarded. `clear_fail`=1 moves to WARMUP, clears `fail`, and clears the run and bit counters. `clear_fail` is ignored in other states.
- **Health test** (when compiled in):
  - Examines every valid bit in WARMUP, COLLECT, ARB and DELIVER.
  - The run counter is 1 on the first bit after reset or clear. It increments when a bit equals the previous bit and reloads to 1 otherwise.
  - On the edge where the run reaches RCT_LIMIT, enter FAIL.
  - Width is `$clog2(RCT_LIMIT+1)`, saturating.

## Timing

- Reset values:
  - state=WARMUP, `gnt`=0, `word_out`=0, `word_valid`=0, `fail`=0.
  - `last`=NREQ-1, so the first grant goes to index 0.
  - All counters 0, previous-bit register 0.
- Reset asserted mid-operation returns everything to reset values on that edge. An outstanding word is lost.
- Latency: if the last bit of a word is sampled at edge N and `req` is already asserted, `gnt` and `word_valid` rise after edge N+1.
- `ack` sampled at edge M drops `word_valid` after M. The next word needs WORD_W further valid bits.
- A single requester holding `req` with immediate `ack` gets one word per WORD_W+2 cycles when `bit_valid` is continuous.
- Simultaneous events:
  - A health trip wins over `ack` in the same cycle. The word is not consumed, and the requester sees `word_valid` fall with no handoff.
  - `clear_fail` and `reset` low together: reset wins.
- `gnt` is never multi-hot. `word_valid`=1 implies `|gnt`=1.

## Configuration

- `TRNG_SCHED_HEALTH_EN` defined: the repetition-count test and FAIL entry are compiled in as described above.
- Undefined:
  - Run counter and previous-bit register are removed.
  - `fail` is tied 0 and FAIL is unreachable.
  - `clear_fail` is unused.
  - All other behaviour is identical.

## Test plan

- **Warm-up discard**: WARMUP_BITS=64, WORD_W=16, alternating bits 1010…, `req`=0001. Bits 0–63 are discarded. `word_out`=16'hAAAA, `gnt`=0001, `word_valid` high the cycle after the ARB edge.
- **Round-robin**: all four `req` held, `ack` returned one cycle after each grant. Grant order is 0,1,2,3,0. No grant is multi-hot.
- **Withdraw**: `req[2]` drops during DELIVER while `req[3]` is held. Return to ARB, same word regranted to index 3, `word_out` unchanged.
- **Health trip**: with macro defined, RCT_LIMIT=32, feed 32 consecutive 1s during COLLECT. `fail`=1 on the 32nd bit edge, `gnt`=0. `clear_fail` restarts WARMUP, and a full 64-bit discard is observed.
- **Trip vs ack**: the trip bit and `ack[g]` arrive in the same cycle. FAIL is entered and no COLLECT occurs.
- **Reset mid-DELIVER**: drive `reset`=0 for one edge. All outputs go to reset values, and the next grant goes to index 0 after warm-up.
